pattern_1_0n_1_generator: RTL and testbench
===========================================

Name: pattern_1_0n_1_generator

Overview:
- Serial transmitter for the "1, N zeros, 1" framing pattern. With the default N=6 it emits 10000001.
- It is the sending end of the team's sequence-detector interface: its serial output feeds a detector's J input.
- A start pulse launches one frame. The gap length is programmable and latched at start.
- Continuous mode reuses each trailing 1 as the next frame's leading 1, so frames overlap.

Parameters:
- CNT_W, 3: width of the gap-length input and the internal gap counter. Maximum gap is 2^CNT_W - 1.
- DEF_GAP, 6: documentation/test default for gap_len. It is not used by the logic.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- gap_len  in  CNT_W  number of 0 bits between the two 1s; latched when start is accepted
- cont  in  1  continuous mode; sampled in TRAIL
- sout  out  1  serial pattern bit
- busy  out  1  high while a frame is on the line
- done  out  1  one-cycle pulse, coincident with each trailing 1

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE.
  - sout, busy and done go to 0.
  - gap_q and counter go to 0.
  - Reset mid-frame aborts the frame immediately. sout drops to 0 asynchronously and no done pulse is produced.
- Outputs are Moore, decoded from the registered state only. There is no combinational path from any input to sout, busy or done.
- States and outputs:
  - IDLE: sout=0, busy=0, done=0.
  - LEAD: sout=1, busy=1, done=0.
  - GAP: sout=0, busy=1, done=0.
  - TRAIL: sout=1, busy=1, done=1.
- Transitions, evaluated each rising clk:
  - IDLE: if start, go to LEAD; latch gap_q<=gap_len and load counter<=gap_len. Otherwise stay in IDLE.
  - LEAD: if counter==0, go to TRAIL; else go to GAP.
  - GAP: decrement counter each cycle. If counter==1 (last zero), go to TRAIL; else stay in GAP.
  - TRAIL, cont=1 and gap_q!=0: go to GAP and reload counter<=gap_q. The trailing 1 serves as the next leading 1.
  - TRAIL, cont=1 and gap_q==0: stay in TRAIL, giving a continuous 1s stream with done high every cycle.
  - TRAIL, cont=0: go to IDLE.
- Latency: start accepted at edge k puts the leading 1 on sout at cycle k+1. The trailing 1 and done appear at cycle k+gap_len+2. busy falls at cycle k+gap_len+3.
- Frame length is gap_len+2 cycles. In continuous mode the period is gap_len+1 cycles.
- start while busy is ignored, with no queuing. A new start is accepted no earlier than the cycle after TRAIL, i.e. in IDLE.
- gap_len changes while busy have no effect, because gap_q holds the value latched at start.
- Counter arithmetic is unsigned CNT_W bits. It never decrements below 1 inside GAP, so no wrap-around occurs. gap_len = 2^CNT_W - 1 is legal.
- Illegal or unused state encodings recover to IDLE on the next clock.

Decomposition:
- Shared package / header holds:
  - State encodings: IDLE=0, LEAD=1, GAP=2, TRAIL=3, as 2-bit localparams.
  - DEF_GAP=6.
- One sub-module, gap_down_counter (parameter CNT_W):
  - Ports: clk, rst, ld, ld_val, dec, cnt, is_zero, is_one.
  - Synchronous load has priority over dec.
  - Asynchronous reset to 0.
- The top level holds the FSM, the gap_q register and the Moore output decode.

Test Plan:
1. Default frame: reset, gap_len=6, start pulsed one cycle, cont=0. Required: sout=1,0,0,0,0,0,0,1 on cycles 1..8 after acceptance; done=1 only on cycle 8; busy=1 on cycles 1..8, 0 on cycle 9.
2. Zero gap: gap_len=0, start. Required: sout=1,1 on cycles 1..2; done on cycle 2; IDLE on cycle 3.
3. Max gap: gap_len=7 (CNT_W=3). Required: a 1, seven 0s, then a 1 (9-cycle frame); done once; no counter wrap.
4. Continuous: gap_len=6, cont held 1, 3 frames. Required: sout pattern 1 000000 1 000000 1 000000 1; done at cycles 8, 15, 22; busy stays 1. Dropping cont before the last TRAIL gives IDLE the next cycle.
5. Start while busy, and gap_len changed mid-frame: start=1 every cycle and gap_len switched 6->2 during GAP. Required: the current frame keeps 6 zeros; the next frame starts only from IDLE (cycle 9 acceptance) and uses gap_len=2.
6. Reset mid-GAP: assert rst on cycle 4 of a frame. Required: sout, busy and done go to 0 immediately; no done pulse; after release, a fresh start produces a full, correct frame.

Source files
------------

// File: rtl/pattern_1_0n_1_generator_pkg.sv
// rtl/pattern_1_0n_1_generator_pkg.sv - shared state encodings, defaults and output decode
// Holds the frame FSM encodings and the Moore decode used by the top level.
package pattern_1_0n_1_generator_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LEAD  = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   localparam logic [1:0] ST_TRAIL = 2'd3;

   localparam int DEF_GAP = 6;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      LEAD  = ST_LEAD,
      GAP   = ST_GAP,
      TRAIL = ST_TRAIL
   } state_t;

   typedef struct packed {
      logic sout;
      logic busy;
      logic done;
   } line_t;

   // Line levels depend on state alone, so nothing from the inputs reaches the outputs.
   function automatic line_t decode_line(input state_t s);
      line_t l;
      l = '{sout: 1'b0, busy: 1'b0, done: 1'b0};
      case (s)
         LEAD:    l = '{sout: 1'b1, busy: 1'b1, done: 1'b0};
         GAP:     l = '{sout: 1'b0, busy: 1'b1, done: 1'b0};
         TRAIL:   l = '{sout: 1'b1, busy: 1'b1, done: 1'b1};
         default: l = '{sout: 1'b0, busy: 1'b0, done: 1'b0};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/gap_down_counter.sv
// rtl/gap_down_counter.sv - loadable down counter for the zero run between the two 1s
// Load wins over decrement; the count holds at zero rather than wrapping.
module gap_down_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             is_zero,
   output logic             is_one
);

   assign is_zero = (cnt == '0);
   assign is_one  = (cnt == CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (ld) begin
         cnt <= ld_val;
      end else if (dec && !is_zero) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/pattern_1_0n_1_generator.sv
// rtl/pattern_1_0n_1_generator.sv - serial "1, N zeros, 1" frame transmitter
// Frame FSM, latched gap length and Moore output decode; the zero count lives in gap_down_counter.
module pattern_1_0n_1_generator
   import pattern_1_0n_1_generator_pkg::*;
#(
   parameter int CNT_W   = 3,
   parameter int DEF_GAP = pattern_1_0n_1_generator_pkg::DEF_GAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] gap_len,
   input  logic             cont,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int MAX_GAP = (1 << CNT_W) - 1;

   if (DEF_GAP < 0 || DEF_GAP > MAX_GAP) begin : g_def_gap_range
      $error("DEF_GAP does not fit in CNT_W bits");
   end

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] gap_q;
   logic             gap_q_ld;
   logic             cnt_ld;
   logic [CNT_W-1:0] cnt_ld_val;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;
   logic             cnt_one;
   line_t            line;

   gap_down_counter #(
      .CNT_W (CNT_W)
   ) u_gap_cnt (
      .clk     (clk),
      .rst     (rst),
      .ld      (cnt_ld),
      .ld_val  (cnt_ld_val),
      .dec     (cnt_dec),
      .cnt     (cnt),
      .is_zero (cnt_zero),
      .is_one  (cnt_one)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_q <= '0;
      end else if (gap_q_ld) begin
         gap_q <= gap_len;
      end
   end

   always_comb begin
      state_nx   = state;
      gap_q_ld   = 1'b0;
      cnt_ld     = 1'b0;
      cnt_ld_val = gap_q;
      cnt_dec    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx   = LEAD;
               gap_q_ld   = 1'b1;
               cnt_ld     = 1'b1;
               cnt_ld_val = gap_len;
            end
         end
         LEAD: begin
            state_nx = cnt_zero ? TRAIL : GAP;
         end
         GAP: begin
            cnt_dec = 1'b1;
            // A zero count here is unreachable; leaving anyway keeps the FSM from sticking.
            if (cnt_one || cnt == '0) begin
               state_nx = TRAIL;
            end
         end
         TRAIL: begin
            if (!cont) begin
               state_nx = IDLE;
            end else if (gap_q != '0) begin
               // The trailing 1 doubles as the next frame's leading 1.
               state_nx   = GAP;
               cnt_ld     = 1'b1;
               cnt_ld_val = gap_q;
            end else begin
               state_nx = TRAIL;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign line = decode_line(state);
   assign sout = line.sout;
   assign busy = line.busy;
   assign done = line.done;

endmodule

// File: tb/tb_pattern_1_0n_1_generator.sv
// tb/tb_pattern_1_0n_1_generator.sv - self-checking bench for pattern_1_0n_1_generator
// Expected line levels come from a frame model built as a bit queue: 1, then per frame N zeros and a 1.
module tb_pattern_1_0n_1_generator;

   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] gap_len;
   logic             cont;
   logic             sout;
   logic             busy;
   logic             done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pattern_1_0n_1_generator #(
      .CNT_W   (CNT_W),
      .DEF_GAP (6)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .gap_len (gap_len),
      .cont    (cont),
      .sout    (sout),
      .busy    (busy),
      .done    (done)
   );

   task automatic chk(input string tag, input logic s, input logic b, input logic d);
      logic [2:0] obs;
      logic [2:0] exp;
      obs = {sout, busy, done};
      exp = {s, b, d};
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: sout/busy/done=%b expected %b", tag, obs, exp);
      end
   endtask

   // Entered at a negedge with the DUT idle; returns at the negedge of the idle cycle after the frame(s).
   task automatic run_frames(input string tag, input int gap, input int nfr,
                             input bit hold, input int new_gap);
      bit exp_q[$];
      int trails;
      bit is_trail;
      exp_q.push_back(1'b1);
      for (int f = 0; f < nfr; f++) begin
         for (int z = 0; z < gap; z++) exp_q.push_back(1'b0);
         exp_q.push_back(1'b1);
      end
      start   = 1'b1;
      gap_len = CNT_W'(gap);
      cont    = 1'b0;
      trails  = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         is_trail = exp_q[i] && (i > 0);
         chk($sformatf("%s c%0d", tag, i + 1), exp_q[i], 1'b1, is_trail);
         if (is_trail) begin
            trails++;
            cont = (trails < nfr);
         end else begin
            cont = 1'($urandom_range(0, 1));
         end
         start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
         gap_len = hold ? CNT_W'(new_gap) : CNT_W'($urandom);
      end
      @(negedge clk);
      chk($sformatf("%s idle", tag), 1'b0, 1'b0, 1'b0);
      start   = hold;
      gap_len = hold ? CNT_W'(new_gap) : gap_len;
      cont    = 1'b0;
   endtask

   task automatic reset_mid(input string tag, input int gap, input int at_cycle);
      start   = 1'b1;
      gap_len = CNT_W'(gap);
      cont    = 1'b0;
      for (int i = 1; i <= at_cycle; i++) begin
         @(negedge clk);
         chk($sformatf("%s c%0d", tag, i), (i == 1), 1'b1, 1'b0);
         start = 1'b0;
      end
      #2 rst = 1'b1;
      #1 chk($sformatf("%s async", tag), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk($sformatf("%s held%0d", tag, i), 1'b0, 1'b0, 1'b0);
      end
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk($sformatf("%s released", tag), 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      gap_len = '0;
      cont    = 1'b0;
      #1 chk("reset", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("reset held", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle after reset", 1'b0, 1'b0, 1'b0);

      run_frames("default", 6, 1, 1'b0, 0);
      run_frames("zero_gap", 0, 1, 1'b0, 0);
      run_frames("max_gap", 7, 1, 1'b0, 0);
      run_frames("cont", 6, 3, 1'b0, 0);
      run_frames("cont_zero", 0, 3, 1'b0, 0);
      run_frames("busy_start", 6, 1, 1'b1, 2);
      run_frames("after_busy", 2, 1, 1'b0, 0);
      reset_mid("rst_gap", 6, 4);
      run_frames("post_rst", 6, 1, 1'b0, 0);
      reset_mid("rst_lead", 5, 1);
      run_frames("post_rst2", 3, 2, 1'b0, 0);

      for (int r = 0; r < 24; r++) begin
         run_frames($sformatf("rnd%0d", r), $urandom_range(0, 7), $urandom_range(1, 3), 1'b0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
